// File: rtl/uart_tx_arbiter.sv
// Two-requester UART TX byte arbiter: CPU strobe FIFO and debug valid/ready FIFO
// share one byte channel under a round-robin, packet-locking grant.
module uart_tx_arbiter #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_BURST = 16,
  parameter logic [7:0]  EOP_BYTE  = 8'h0A
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       cpu_wd,
  input  logic [7:0] cpu_data,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  output logic       dbg_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       cpu_overflow,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_DBG} state_t;

  logic [7:0]    r_cpu_mem [DEPTH];
  logic [7:0]    r_dbg_mem [DEPTH];
  logic [AW-1:0] r_cpu_wp, r_cpu_rp, r_dbg_wp, r_dbg_rp;
  logic [CW-1:0] r_cpu_cnt, r_dbg_cnt;
  state_t        r_state;
  logic          r_rr_dbg;
  logic [7:0]    r_burst_cnt;
  logic          r_cpu_ovf;

  state_t     w_state_nxt;
  logic       w_rr_nxt;
  logic       w_cpu_full, w_cpu_empty, w_dbg_full, w_dbg_empty;
  logic       w_cpu_push, w_dbg_push, w_cpu_pop, w_dbg_pop;
  logic       w_hs, w_burst_clr;
  logic       w_tx_valid;
  logic [7:0] w_tx_data, w_cpu_head, w_dbg_head;
  logic [1:0] w_grant;

  // Status comes from the registered counts, so a same-cycle pop never frees a slot.
  assign w_cpu_full  = (r_cpu_cnt == CW'(DEPTH));
  assign w_cpu_empty = (r_cpu_cnt == '0);
  assign w_dbg_full  = (r_dbg_cnt == CW'(DEPTH));
  assign w_dbg_empty = (r_dbg_cnt == '0);
  assign w_cpu_push  = cpu_wd & ~w_cpu_full;
  assign w_dbg_push  = dbg_valid & ~w_dbg_full & ~areset;
  assign w_cpu_head  = r_cpu_mem[r_cpu_rp];
  assign w_dbg_head  = r_dbg_mem[r_dbg_rp];

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_dbg;
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    w_grant     = 2'b00;
    w_cpu_pop   = 1'b0;
    w_dbg_pop   = 1'b0;
    w_hs        = 1'b0;
    w_burst_clr = 1'b0;
    case (r_state)
      IDLE: begin
        w_burst_clr = 1'b1;
        if (!w_cpu_empty && (w_dbg_empty || !r_rr_dbg))
          w_state_nxt = GRANT_CPU;
        else if (!w_dbg_empty)
          w_state_nxt = GRANT_DBG;
      end
      GRANT_CPU: begin
        w_grant    = 2'b01;
        w_tx_valid = ~w_cpu_empty;
        w_tx_data  = w_tx_valid ? w_cpu_head : 8'h00;
        w_hs       = w_tx_valid & tx_ready;
        w_cpu_pop  = w_hs;
        if (w_cpu_empty || (w_hs && (w_cpu_head == EOP_BYTE ||
                                     r_burst_cnt == 8'(MAX_BURST - 1)))) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = 1'b1;
        end
      end
      GRANT_DBG: begin
        w_grant    = 2'b10;
        w_tx_valid = ~w_dbg_empty;
        w_tx_data  = w_tx_valid ? w_dbg_head : 8'h00;
        w_hs       = w_tx_valid & tx_ready;
        w_dbg_pop  = w_hs;
        if (w_dbg_empty || (w_hs && (w_dbg_head == EOP_BYTE ||
                                     r_burst_cnt == 8'(MAX_BURST - 1)))) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; only pointers and counts define what is queued.
  always_ff @(posedge clk) begin
    if (w_cpu_push) r_cpu_mem[r_cpu_wp] <= cpu_data;
    if (w_dbg_push) r_dbg_mem[r_dbg_wp] <= dbg_data;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      r_cpu_wp    <= '0;
      r_cpu_rp    <= '0;
      r_cpu_cnt   <= '0;
      r_dbg_wp    <= '0;
      r_dbg_rp    <= '0;
      r_dbg_cnt   <= '0;
      r_state     <= IDLE;
      r_rr_dbg    <= 1'b0;
      r_burst_cnt <= 8'h00;
      r_cpu_ovf   <= 1'b0;
    end else begin
      r_cpu_wp    <= r_cpu_wp + AW'(w_cpu_push);
      r_cpu_rp    <= r_cpu_rp + AW'(w_cpu_pop);
      r_cpu_cnt   <= r_cpu_cnt + CW'(w_cpu_push) - CW'(w_cpu_pop);
      r_dbg_wp    <= r_dbg_wp + AW'(w_dbg_push);
      r_dbg_rp    <= r_dbg_rp + AW'(w_dbg_pop);
      r_dbg_cnt   <= r_dbg_cnt + CW'(w_dbg_push) - CW'(w_dbg_pop);
      r_state     <= w_state_nxt;
      r_rr_dbg    <= w_rr_nxt;
      r_burst_cnt <= w_burst_clr ? 8'h00 : r_burst_cnt + 8'(w_hs);
      r_cpu_ovf   <= r_cpu_ovf | (cpu_wd & w_cpu_full);
    end
  end

  assign tx_valid     = w_tx_valid & ~areset;
  assign tx_data      = areset ? 8'h00 : w_tx_data;
  assign grant        = areset ? 2'b00 : w_grant;
  assign dbg_ready    = ~w_dbg_full & ~areset;
  assign busy         = ~areset & ((r_state != IDLE) | ~w_cpu_empty | ~w_dbg_empty);
  assign cpu_overflow = r_cpu_ovf;

endmodule
